// File: rtl/add_pkg.sv
// Shared types and constants for the byte-serial add scheduler.
package add_pkg;

  typedef enum logic [1:0] {
    IDLE,
    STEP,
    DONE
  } sched_state_t;

  localparam int BYTE_W = 8;
  localparam int NSTEP  = 4;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: rotating search pointer, one-hot grant.
module rr_arbiter #(
  parameter int NREQ = 4,
  parameter int IW   = $clog2(NREQ)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [NREQ-1:0] req,
  input  logic            update,
  output logic [NREQ-1:0] gnt,
  output logic [IW-1:0]   gnt_id
);

  logic [IW-1:0] ptr_q, ptr_d;

  // Walk from the far end back to the pointer so the nearest
  // valid requester is the one left standing.
  always_comb begin
    int idx;
    idx    = 0;
    gnt    = '0;
    gnt_id = '0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      idx = (int'(ptr_q) + i) % NREQ;
      if (req[idx]) begin
        gnt      = '0;
        gnt[idx] = 1'b1;
        gnt_id   = IW'(idx);
      end
    end
  end

  always_comb begin
    ptr_d = ptr_q;
    if (update) begin
      ptr_d = IW'((int'(gnt_id) + 1) % NREQ);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

endmodule

// File: rtl/add32_sched.sv
// Shares one byte-serial 32-bit adder among NREQ requesters,
// round-robin arbitrated, LSB first with a registered carry.
import add_pkg::*;

module add32_sched #(
  parameter int NREQ = 4,
  parameter int ID_W = $clog2(NREQ)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               adv,
  input  logic [NREQ-1:0]    req_valid,
  output logic [NREQ-1:0]    req_ready,
  input  logic [NREQ*32-1:0] req_a,
  input  logic [NREQ*32-1:0] req_b,
  output logic               rsp_valid,
  input  logic               rsp_ready,
  output logic [ID_W-1:0]    rsp_id,
  output logic [31:0]        rsp_sum,
  output logic               rsp_c8
);

  localparam int NW = $clog2(NSTEP);

  sched_state_t state_q, state_d;

  logic [31:0]     a_q, a_d;
  logic [31:0]     b_q, b_d;
  logic [31:0]     acc_q, acc_d;
  logic            c_q, c_d;
  logic [NW-1:0]   n_q, n_d;
  logic [ID_W-1:0] id_q, id_d;
  logic [31:0]     sum_q, sum_d;
  logic            c8_q, c8_d;
  logic [ID_W-1:0] rid_q, rid_d;

  logic [NREQ-1:0] gnt;
  logic [ID_W-1:0] gnt_id;
  logic            upd;
  logic [BYTE_W:0] bsum;

  rr_arbiter #(
    .NREQ (NREQ),
    .IW   (ID_W)
  ) u_arb (
    .clk    (clk),
    .rst    (rst),
    .req    (req_valid),
    .update (upd),
    .gnt    (gnt),
    .gnt_id (gnt_id)
  );

  assign bsum = {1'b0, a_q[BYTE_W-1:0]}
              + {1'b0, b_q[BYTE_W-1:0]}
              + {{BYTE_W{1'b0}}, c_q};

  always_comb begin
    state_d   = state_q;
    a_d       = a_q;
    b_d       = b_q;
    acc_d     = acc_q;
    c_d       = c_q;
    n_d       = n_q;
    id_d      = id_q;
    sum_d     = sum_q;
    c8_d      = c8_q;
    rid_d     = rid_q;
    upd       = 1'b0;
    req_ready = '0;
    unique case (state_q)
      IDLE: begin
        req_ready = rst ? gnt : '0;
        if (|(req_valid & req_ready)) begin
          upd     = 1'b1;
          a_d     = req_a[int'(gnt_id)*32 +: 32];
          b_d     = req_b[int'(gnt_id)*32 +: 32];
          id_d    = gnt_id;
          c_d     = 1'b0;
          n_d     = '0;
          state_d = STEP;
        end
      end
      STEP: begin
        if (adv) begin
          // Operands shift down; result bytes enter from the top.
          acc_d = {bsum[BYTE_W-1:0], acc_q[31:BYTE_W]};
          c_d   = bsum[BYTE_W];
          a_d   = a_q >> BYTE_W;
          b_d   = b_q >> BYTE_W;
          n_d   = n_q + NW'(1);
          if (n_q == NW'(NSTEP - 1)) begin
            sum_d   = {bsum[BYTE_W-1:0], acc_q[31:BYTE_W]};
            c8_d    = bsum[BYTE_W];
            rid_d   = id_q;
            state_d = DONE;
          end
        end
      end
      DONE: begin
        if (rsp_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      acc_q   <= '0;
      c_q     <= 1'b0;
      n_q     <= '0;
      id_q    <= '0;
      sum_q   <= '0;
      c8_q    <= 1'b0;
      rid_q   <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      acc_q   <= acc_d;
      c_q     <= c_d;
      n_q     <= n_d;
      id_q    <= id_d;
      sum_q   <= sum_d;
      c8_q    <= c8_d;
      rid_q   <= rid_d;
    end
  end

  assign rsp_valid = (state_q == DONE);
  assign rsp_sum   = sum_q;
  assign rsp_c8    = c8_q;
  assign rsp_id    = rid_q;

endmodule

// File: doc/add32_sched.md
# add32_sched

Round-robin scheduler that shares one byte-serial 32-bit adder among `NREQ` requesters. It accepts one operand pair at a time over a valid/ready handshake and sequences the addition as four 8-bit steps, least-significant byte first, with a registered carry. It returns the sum, the carry out of bit 31 and the requester id over a valid/ready response port. It sits between the requesting units and the shared add resource, and owns all arbitration and step sequencing.

## Interface
Parameters:
- `NREQ`, default 4: number of requesters, 2..8.
- `ID_W`, default `$clog2(NREQ)`: requester id width.

Ports:
- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `adv`  in  1  step enable; a STEP cycle advances only when `adv`=1.
- `req_valid`  in  `NREQ`  per-requester request valid.
- `req_ready`  out  `NREQ`  per-requester accept, one-hot or zero.
- `req_a`  in  `NREQ`x32  operand A per requester.
- `req_b`  in  `NREQ`x32  operand B per requester.
- `rsp_valid`  out  1  result valid.
- `rsp_ready`  in  1  consumer accepts result.
- `rsp_id`  out  `ID_W`  index of the requester that owns the result.
- `rsp_sum`  out  32  A+B mod 2^32.
- `rsp_c8`  out  1  carry out of bit 31.

## Operation
- States: IDLE, STEP, DONE.
- **IDLE**
  - `req_ready[k]`=1 combinationally only for the arbitration winner k.
  - On `req_valid[k]` & `req_ready[k]`: capture A and B into operand registers, set id=k, clear carry, set byte counter to 0, go to STEP.
  - No valid requesters: stay in IDLE.
- **Arbitration**
  - Search starts at pointer p and proceeds p, p+1, ... mod `NREQ`; the first valid requester wins.
  - After a grant to k, p becomes (k+1) mod `NREQ`.
  - p is unchanged when there is no grant.
- **STEP**, when `adv`=1:
  - {carry, sum byte[n]} = A byte[n] + B byte[n] + carry.
  - n increments; after n=3, go to DONE.
  - With `adv`=0, all state holds.
- **DONE**
  - `rsp_valid`=1; `rsp_sum`, `rsp_c8` and `rsp_id` are stable.
  - On `rsp_ready`=1, go to IDLE.
  - `rsp_valid` deasserts in the next cycle. The outputs keep their last value until the next DONE.
- `req_ready` is 0 in every state except IDLE.
- Requesters hold `req_valid`, `req_a` and `req_b` until accepted. A request withdrawn before accept is simply not granted.
- Reset, asynchronous and applicable in any state, including mid-STEP:
  - state goes to IDLE and p to 0;
  - `rsp_valid`, `rsp_sum`, `rsp_c8` and `rsp_id` go to 0;
  - `req_ready` is forced to 0 while `rst`=0;
  - an in-flight operation is discarded with no response.

## Timing
- Accept in cycle 0. STEP occupies cycles 1-4 with `adv`=1, and `rsp_valid`=1 from cycle 5.
- Latency is 5 cycles plus one cycle per STEP cycle with `adv`=0.
- In DONE with `rsp_ready`=1 in cycle 5, IDLE is in cycle 6 and the next accept is possible in cycle 6.
- Minimum spacing between accepts is 6 cycles.
- `req_ready` depends only on state, p and `req_valid`; it has no path from `rsp_ready`.
- Simultaneous requests resolve in the same cycle; only one requester is ready per cycle.

## Structure
- Package `add_pkg` holds:
  - the state enum `sched_state_t` (IDLE, STEP, DONE);
  - `BYTE_W`=8;
  - `NSTEP`=4.
- Sub-module `rr_arbiter`, parameterised by `NREQ`:
  - holds the pointer register;
  - produces a one-hot grant from `req_valid` and an `update` strobe.
- The top level holds the FSM, operand, sum, carry and counter registers, and the byte-step adder.

## Test plan
- **Single request:** req0 with A=0x0000000A, B=0x0000000A, `adv`=1 → `rsp_valid` 5 cycles after accept, `rsp_sum`=0x00000014, `rsp_c8`=0, `rsp_id`=0.
- **Full carry ripple:** A=0xFFFFFFFF, B=0x00000001 → `rsp_sum`=0x00000000, `rsp_c8`=1.
- **Round-robin from reset:** all four requesters held valid with `rsp_ready`=1 → grant order 0,1,2,3,0. A new request from requester 2 arriving while 3 is busy does not pre-empt 3.
- **Backpressure:** `rsp_ready`=0 for 3 cycles in DONE → `rsp_valid`, `rsp_sum` and `rsp_id` stable throughout, all `req_ready`=0, and IDLE the cycle after `rsp_ready`=1.
- **Stall:** A=0x12345678, B=0x0FEDCBA9, with `adv`=0 for 2 cycles at step 2 → latency 7, `rsp_sum`=0x22222221, `rsp_c8`=0.
- **Reset mid-STEP:** `rst`=0 during step 1 → immediately `rsp_valid`=0 and all outputs 0. After release, the first grant goes to requester 0 and no response is emitted for the aborted operation.
